// File: rtl/mem_dump_pkg.sv
// Shared types and helpers for the memory-dump UART transmitter.
// Holds the word-level FSM states, the byte-serializer states and the baud divider.
package mem_dump_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    SEND,
    NEXT
  } top_state_e;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_e;

  localparam int BYTES_PER_WORD = 4;

  // Clock cycles per serial bit; integer division truncates toward zero.
  function automatic int calc_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/mem_dump_uart_tx_byte.sv
// 8N1 byte serializer with a baud counter and a load/ready handshake.
// ready rises in the final cycle of the stop bit so back-to-back bytes leave no idle gap.
module uart_byte_tx
  import mem_dump_pkg::*;
#(
  parameter int DIV = 86
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int              CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  byte_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ready   = 1'b0;
    tx      = 1'b1;
    if (state_q != B_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      B_IDLE: ready = 1'b1;
      B_START: begin
        tx = 1'b0;
        if (bit_end) begin
          state_d = B_DATA;
          bit_d   = 3'd0;
        end
      end
      B_DATA: begin
        tx = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = B_STOP;
        end
      end
      B_STOP: begin
        ready = bit_end;
        if (bit_end) state_d = B_IDLE;
      end
      default: state_d = B_IDLE;
    endcase
    // A load accepted on the last stop cycle chains straight into the next start bit.
    if (load && ready) begin
      state_d = B_START;
      cnt_d   = '0;
      shift_d = data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= B_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

endmodule

// File: rtl/mem_dump_uart_tx.sv
// Reads a block of 32-bit words from memory and streams each one over UART,
// little-endian, with a fixed three-cycle idle gap between words.
module mem_dump_uart_tx
  import mem_dump_pkg::*;
#(
  parameter int CLK_HZ = 10_000_000,
  parameter int BAUD   = 115200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [14:0] base_addr,
  input  logic [14:0] word_count,
  output logic        mem_rd,
  output logic [14:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  top_state_e  state_q, state_d;
  logic [14:0] addr_q, addr_d;
  logic [14:0] remain_q, remain_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  byte_q, byte_d;
  logic [1:0]  nxt_byte;
  logic        done_q, done_d;
  logic        byte_load, byte_ready;
  logic [7:0]  byte_data;

  assign nxt_byte = byte_q + 2'd1;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    word_d    = word_q;
    byte_d    = byte_q;
    done_d    = 1'b0;
    byte_load = 1'b0;
    byte_data = word_q[7:0];
    mem_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (word_count != 15'd0) begin
            addr_d   = base_addr;
            remain_d = word_count;
            state_d  = READ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      READ: begin
        mem_rd  = 1'b1;
        state_d = CAPTURE;
      end
      CAPTURE: begin
        word_d    = mem_data;
        byte_d    = 2'd0;
        byte_load = 1'b1;
        byte_data = mem_data[7:0];
        state_d   = SEND;
      end
      SEND: begin
        if (byte_ready) begin
          if (byte_q == 2'(BYTES_PER_WORD - 1)) begin
            state_d = NEXT;
          end else begin
            byte_load = 1'b1;
            byte_d    = nxt_byte;
            byte_data = word_q[{nxt_byte, 3'b000} +: 8];
          end
        end
      end
      NEXT: begin
        remain_d = remain_q - 15'd1;
        addr_d   = addr_q + 15'd1;
        if (remain_q == 15'd1) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      byte_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      byte_q   <= byte_d;
      done_q   <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign mem_addr = addr_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

  uart_byte_tx #(
    .DIV(DIV)
  ) u_byte_tx (
    .clk  (clk),
    .reset(reset),
    .load (byte_load),
    .data (byte_data),
    .ready(byte_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_mem_dump_uart_tx.sv
// Randomized bench for mem_dump_uart_tx: a memory array model plus an expected
// line waveform built from the UART framing rules, checked cycle by cycle.
module tb_mem_dump_uart_tx;

  localparam int DIV_F = 10;
  localparam int DIV_D = 86;

  logic        clk = 1'b0;
  logic        reset, start, sel_def;
  logic [14:0] base_addr, word_count;
  logic [31:0] mem_data;
  logic        start_f, start_d;
  logic        rd_f, rd_d, tx_f, tx_d, busy_f, busy_d, done_f, done_d;
  logic [14:0] addr_f, addr_d;
  logic        obs_rd, obs_tx, obs_busy, obs_done;
  logic [14:0] obs_addr;

  logic [31:0] mem [0:32767];

  int n_tests = 0;
  int n_fail  = 0;

  bit          tx_s[$];
  bit          busy_s[$];
  int          rd_idx[$];
  logic [14:0] rd_adr[$];
  int          done_idx[$];

  always #5 clk = ~clk;

  assign start_f  = start & ~sel_def;
  assign start_d  = start & sel_def;
  assign obs_rd   = sel_def ? rd_d   : rd_f;
  assign obs_tx   = sel_def ? tx_d   : tx_f;
  assign obs_busy = sel_def ? busy_d : busy_f;
  assign obs_done = sel_def ? done_d : done_f;
  assign obs_addr = sel_def ? addr_d : addr_f;

  mem_dump_uart_tx #(.CLK_HZ(10_000_000), .BAUD(1_000_000)) u_dut_fast (
    .clk(clk), .reset(reset), .start(start_f), .base_addr(base_addr),
    .word_count(word_count), .mem_rd(rd_f), .mem_addr(addr_f),
    .mem_data(mem_data), .tx(tx_f), .busy(busy_f), .done(done_f)
  );

  mem_dump_uart_tx u_dut_def (
    .clk(clk), .reset(reset), .start(start_d), .base_addr(base_addr),
    .word_count(word_count), .mem_rd(rd_d), .mem_addr(addr_d),
    .mem_data(mem_data), .tx(tx_d), .busy(busy_d), .done(done_d)
  );

  // Memory answers one cycle after a read; junk otherwise so mistimed captures show up.
  always @(posedge clk) begin
    if (obs_rd) mem_data <= mem[obs_addr];
    else        mem_data <= $urandom;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample ncyc cycles; index 0 is the cycle after start was sampled.
  task automatic record(input int ncyc, input int inj_at);
    tx_s.delete(); busy_s.delete(); rd_idx.delete(); rd_adr.delete(); done_idx.delete();
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      tx_s.push_back(obs_tx);
      busy_s.push_back(obs_busy);
      if (obs_rd) begin
        rd_idx.push_back(i);
        rd_adr.push_back(obs_addr);
      end
      if (obs_done) done_idx.push_back(i);
      start = (i == inj_at);
      if (i == inj_at) begin
        base_addr  = ~base_addr;
        word_count = 15'd5;
      end
    end
    start = 1'b0;
  endtask

  task automatic check_dump(input logic [14:0] base, input logic [14:0] cnt, input int div,
                            input string name);
    int          per, total, nm, first_bad, bm, stop_bad;
    bit          exp_tx[$];
    logic [7:0]  exp_b[$];
    logic [7:0]  dec_b[$];
    int          starts[$];
    logic [14:0] a;
    logic [31:0] w;
    logic [7:0]  b;
    int          i;
    per   = 40 * div + 3;
    total = int'(cnt) * per;
    for (int k = 0; k < int'(cnt); k++) begin
      a = base + 15'(k);
      w = mem[a];
      exp_tx.push_back(1'b1);
      exp_tx.push_back(1'b1);
      for (int by = 0; by < 4; by++) begin
        b = w[8*by +: 8];
        exp_b.push_back(b);
        for (int c = 0; c < div; c++) exp_tx.push_back(1'b0);
        for (int bit_n = 0; bit_n < 8; bit_n++)
          for (int c = 0; c < div; c++) exp_tx.push_back(b[bit_n]);
        for (int c = 0; c < div; c++) exp_tx.push_back(1'b1);
      end
      exp_tx.push_back(1'b1);
    end
    while (exp_tx.size() < tx_s.size()) exp_tx.push_back(1'b1);

    nm = 0; first_bad = -1; bm = 0;
    for (int k = 0; k < tx_s.size(); k++) begin
      if (tx_s[k] != exp_tx[k]) begin
        nm++;
        if (first_bad < 0) first_bad = k;
      end
      if (busy_s[k] != (k < total)) bm++;
    end
    chk({name, ":tx_wave_mismatches"}, nm, 0);
    if (nm != 0) $display("  %s first tx deviation at cycle %0d", name, first_bad);
    chk({name, ":busy_mismatches"}, bm, 0);

    chk({name, ":rd_count"}, rd_idx.size(), int'(cnt));
    for (int k = 0; k < rd_idx.size() && k < int'(cnt); k++) begin
      a = base + 15'(k);
      chk({name, ":rd_addr"}, int'(rd_adr[k]), int'(a));
      chk({name, ":rd_cycle"}, rd_idx[k], k * per);
    end

    chk({name, ":done_count"}, done_idx.size(), 1);
    if (done_idx.size() > 0) chk({name, ":done_cycle"}, done_idx[0], total);

    // Independent UART receiver: detect start bit, sample mid-bit.
    stop_bad = 0;
    i = 0;
    while (i < tx_s.size()) begin
      if (tx_s[i] == 1'b0 && i + 10 * div <= tx_s.size()) begin
        for (int k = 0; k < 8; k++) b[k] = tx_s[i + div/2 + div*(k+1)];
        if (tx_s[i + div/2 + 9*div] != 1'b1) stop_bad++;
        dec_b.push_back(b);
        starts.push_back(i);
        i += 10 * div;
      end else begin
        i++;
      end
    end
    chk({name, ":byte_count"}, dec_b.size(), exp_b.size());
    chk({name, ":stop_bits_bad"}, stop_bad, 0);
    for (int k = 0; k < dec_b.size() && k < exp_b.size(); k++)
      chk({name, ":byte"}, int'(dec_b[k]), int'(exp_b[k]));
    for (int k = 1; k < starts.size(); k++)
      chk({name, ":frame_gap"}, starts[k] - starts[k-1], (k % 4 == 0) ? 10*div + 3 : 10*div);
  endtask

  // Must be called at a negedge; start is sampled on the following rising edge.
  task automatic do_dump(input logic [14:0] base, input logic [14:0] cnt, input int div,
                         input int inj_at, input string name);
    int ncyc;
    ncyc       = int'(cnt) * (40 * div + 3) + 4;
    base_addr  = base;
    word_count = cnt;
    start      = 1'b1;
    record(ncyc, inj_at);
    check_dump(base, cnt, div, name);
  endtask

  initial begin
    logic [14:0] rb;
    logic [14:0] rc;
    for (int k = 0; k < 32768; k++) mem[k] = $urandom;
    reset = 1'b1; start = 1'b0; sel_def = 1'b0;
    base_addr = '0; word_count = '0;
    repeat (3) @(negedge clk);
    chk("rst:tx",      int'(obs_tx),   1);
    chk("rst:busy",    int'(obs_busy), 0);
    chk("rst:done",    int'(obs_done), 0);
    chk("rst:mem_rd",  int'(obs_rd),   0);
    chk("rst:def_tx",  int'(tx_d),     1);
    reset = 1'b0;
    @(negedge clk);

    mem[15'h4000] = 32'h1234_5678;
    do_dump(15'h4000, 15'd1, DIV_F, -1, "single");
    do_dump(15'h0123, 15'd0, DIV_F, -1, "zero");
    do_dump(15'h7FFF, 15'd2, DIV_F, -1, "wrap");
    do_dump(15'(17 + $urandom_range(0, 30000)), 15'd2, DIV_F, 150, "ignore_start");

    // Abort during a data bit, then restart on the first cycle out of reset.
    base_addr = 15'h2222; word_count = 15'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2 + DIV_F + 3) @(negedge clk);
    chk("abort:busy_before", int'(obs_busy), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("abort:tx",       int'(obs_tx),   1);
    chk("abort:busy",     int'(obs_busy), 0);
    chk("abort:done",     int'(obs_done), 0);
    chk("abort:mem_rd",   int'(obs_rd),   0);
    chk("abort:mem_addr", int'(obs_addr), 0);
    reset = 1'b0;
    do_dump(15'h1357, 15'd1, DIV_F, -1, "after_reset");

    for (int t = 0; t < 4; t++) begin
      rb = 15'($urandom_range(0, 32767));
      rc = 15'($urandom_range(1, 3));
      do_dump(rb, rc, DIV_F, -1, "random");
    end

    sel_def = 1'b1;
    @(negedge clk);
    do_dump(15'($urandom_range(0, 32767)), 15'd1, DIV_D, -1, "default_baud");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dump_uart_tx.md
MEM_DUMP_UART_TX -- requirements
Module: mem_dump_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 10_000_000, the frequency of clk (the uart_clk domain).
REQ-002 SHALL have parameter BAUD, default 115200, the serial bit rate; DIV = CLK_HZ/BAUD, truncated (default 86).
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a dump.
REQ-006 SHALL have port base_addr  input  15  first word address, same map as upg_addr (bit14=1 DMem, 0 IMem).
REQ-007 SHALL have port word_count  input  15  number of 32-bit words to send.
REQ-008 SHALL have port mem_rd  output  1  memory read strobe.
REQ-009 SHALL have port mem_addr  output  15  word address for the read.
REQ-010 SHALL have port mem_data  input  32  read data, valid exactly one cycle after mem_rd.
REQ-011 SHALL have port tx  output  1  UART line, 8N1, LSB first, idle high.
REQ-012 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-013 SHALL have port done  output  1  one-cycle pulse at dump completion.

Function
REQ-014 SHALL use top FSM states IDLE, READ, CAPTURE, SEND, NEXT.
REQ-015 In IDLE, start=1 with word_count!=0 SHALL latch base_addr and word_count, then go to READ with busy=1.
REQ-016 In IDLE, start=1 with word_count=0 SHALL pulse done on the next cycle, with no mem_rd, tx held high and busy held 0.
REQ-017 READ SHALL assert mem_rd=1 with mem_addr=current address for exactly one cycle, then go to CAPTURE.
REQ-018 CAPTURE SHALL latch mem_data into a 32-bit word register, clear the byte index, then go to SEND.
REQ-019 SEND SHALL transmit 4 bytes little-endian (bits[7:0] first), each as start bit 0, 8 data bits LSB first, then stop bit 1.
REQ-020 Each bit in SEND SHALL last exactly DIV clk cycles, with no idle gap between bytes of one word.
REQ-021 After the 4th stop bit, SEND SHALL go to NEXT.
REQ-022 NEXT SHALL decrement the remaining count and increment the address modulo 2^15 (0x7FFF wraps to 0x0000).
REQ-023 From NEXT, the FSM SHALL go to IDLE with done=1 for one cycle if the remaining count is 0, otherwise to READ.
REQ-024 tx SHALL be high in every state except the start and data bits of SEND.
REQ-025 The inter-word gap SHALL be exactly 3 idle-high cycles (NEXT, READ, CAPTURE).
REQ-026 start SHALL be ignored whenever busy=1; base_addr and word_count SHALL be sampled only on an accepted start.
REQ-027 Total dump length SHALL be word_count*(40*DIV+3) cycles from the first READ to the done pulse.

Reset
REQ-028 On reset=1 at a clock edge, the block SHALL force tx=1, busy=0, done=0, mem_rd=0, mem_addr=0, FSM=IDLE and the bit/byte counters to 0.
REQ-029 Reset mid-frame SHALL abort immediately with no done pulse, and start SHALL be accepted on the first cycle after reset deasserts.

Structure
REQ-030 Package mem_dump_pkg SHALL hold the top FSM state enum, the byte-serializer state enum (B_IDLE, B_START, B_DATA, B_STOP) and the DIV computation function.
REQ-031 One sub-module, uart_byte_tx, SHALL implement the per-byte baud counter and serializer with a load/ready handshake, and SHALL be instantiated once.

Verification
REQ-032 The bench SHALL cover, with CLK_HZ=10_000_000 and BAUD=1_000_000 (DIV=10): base_addr 0x4000, count 1, mem_data 0x12345678 -> mem_rd once at 0x4000; tx bytes 0x78, 0x56, 0x34, 0x12; 100-cycle frames; done 403 cycles after the READ cycle.
REQ-033 The bench SHALL cover: count 0 -> done pulse on the cycle after start, tx never low, mem_rd never high, busy never high.
REQ-034 The bench SHALL cover: base_addr 0x7FFF, count 2 -> mem_addr 0x7FFF then 0x0000, 8 bytes sent, exactly 3 idle cycles between words.
REQ-035 The bench SHALL cover: start pulsed mid-dump with different base_addr -> ignored, byte count and addresses unchanged.
REQ-036 The bench SHALL cover: reset asserted during a data bit -> tx=1, busy=0 next cycle, no done; a new start succeeds the cycle after reset deasserts.
REQ-037 The bench SHALL cover: default parameters -> every bit period exactly 86 cycles.
